// File: rtl/dft64_sample_framer.sv
// Collects a serial stream of signed samples into one frame and replays it to
// dft64 as consecutive multi-lane beats, then waits (bounded) for dft64 done.
module dft64_sample_framer #(
    parameter int SAMPLE_W     = 16,
    parameter int LANES        = 8,
    parameter int FRAME_LEN    = 64,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      sreset,
    input  logic [SAMPLE_W-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [SAMPLE_W*LANES-1:0] samples,
    output logic                      rel,
    output logic                      calculate,
    input  logic                      done,
    output logic                      busy,
    output logic [15:0]               frame_count,
    output logic                      timeout_err
);

    localparam int BEATS  = FRAME_LEN / LANES;
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int LANE_W = $clog2(LANES);
    localparam int ADDR_W = $clog2(BEATS);
    localparam int BCNT_W = $clog2(BEATS + 1);
    localparam int TO_W   = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [IDX_W-1:0]    wr_idx_reg;
    logic [BCNT_W-1:0]   beat_cnt_reg;
    logic [TO_W-1:0]     to_cnt_reg;
    logic                rel_reg;
    logic                calc_reg;
    logic                busy_reg;
    logic                err_reg;
    logic [15:0]         fc_reg;

    logic                accept;
    logic                last_sample;
    logic                issue_end;
    logic                timeout_hit;
    logic                load_beat;
    logic [ADDR_W-1:0]   rd_addr;

    // Held low through the reset cycle itself so nothing is accepted while
    // the buffer is being discarded.
    assign in_ready    = (state_reg == FILL) && !sreset;
    assign accept      = in_valid && in_ready;
    assign last_sample = accept && (wr_idx_reg == IDX_W'(FRAME_LEN - 1));
    assign issue_end   = (state_reg == ISSUE) && (beat_cnt_reg == BCNT_W'(BEATS));
    assign timeout_hit = (to_cnt_reg == TO_W'(DONE_TIMEOUT - 1));

    // Beat 0 is fetched on the edge that accepts the final sample, so rel is
    // already high in the first ISSUE cycle; beat_cnt_reg then names the next beat.
    always_comb begin
        load_beat = 1'b0;
        rd_addr   = '0;
        if (last_sample) begin
            load_beat = 1'b1;
            rd_addr   = '0;
        end else if ((state_reg == ISSUE) && !issue_end) begin
            load_beat = 1'b1;
            rd_addr   = beat_cnt_reg[ADDR_W-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: begin
                if (last_sample) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_end) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done || timeout_hit) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            wr_idx_reg   <= '0;
            beat_cnt_reg <= '0;
            to_cnt_reg   <= '0;
            rel_reg      <= 1'b0;
            calc_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            fc_reg       <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (last_sample) begin
                            wr_idx_reg   <= '0;
                            beat_cnt_reg <= BCNT_W'(1);
                            rel_reg      <= 1'b1;
                            calc_reg     <= 1'b1;
                            busy_reg     <= 1'b1;
                        end else begin
                            wr_idx_reg <= wr_idx_reg + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_end) begin
                        rel_reg      <= 1'b0;
                        beat_cnt_reg <= '0;
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // done on the last allowed cycle still counts as success
                    if (done) begin
                        fc_reg     <= fc_reg + 16'd1;
                        calc_reg   <= 1'b0;
                        busy_reg   <= 1'b0;
                        to_cnt_reg <= '0;
                    end else if (timeout_hit) begin
                        err_reg    <= 1'b1;
                        calc_reg   <= 1'b0;
                        busy_reg   <= 1'b0;
                        to_cnt_reg <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One narrow memory per lane so a whole beat is read in a single cycle;
    // sample i lands in lane i%LANES at beat address i/LANES.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SAMPLE_W-1:0] mem [BEATS];
            logic [SAMPLE_W-1:0] rd_reg;

            always_ff @(posedge clk) begin
                if (accept && (wr_idx_reg[LANE_W-1:0] == LANE_W'(gi))) begin
                    mem[wr_idx_reg[IDX_W-1:LANE_W]] <= in_data;
                end
            end

            always_ff @(posedge clk) begin
                if (sreset) begin
                    rd_reg <= '0;
                end else if (load_beat) begin
                    rd_reg <= mem[rd_addr];
                end
            end

            assign samples[SAMPLE_W*(LANES-gi)-1 -: SAMPLE_W] = rd_reg;
        end
    endgenerate

    assign rel         = rel_reg;
    assign calculate   = calc_reg;
    assign busy        = busy_reg;
    assign frame_count = fc_reg;
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_dft64_sample_framer.sv
// Directed/randomised bench for dft64_sample_framer; expected beats, counts and
// error flag come from a frame-level model of the accepted sample stream.
module tb_dft64_sample_framer;

    logic         clk = 1'b0;
    logic         sreset;
    logic [15:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] samples;
    logic         rel;
    logic         calculate;
    logic         done;
    logic         busy;
    logic [15:0]  frame_count;
    logic         timeout_err;

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] cur [64];
    logic [15:0] exp_fc;
    logic        exp_err;

    always #5 clk = ~clk;

    dft64_sample_framer dut (
        .clk         (clk),
        .sreset      (sreset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .samples     (samples),
        .rel         (rel),
        .calculate   (calculate),
        .done        (done),
        .busy        (busy),
        .frame_count (frame_count),
        .timeout_err (timeout_err)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat k of the model frame: earliest sample of the group in the MSBs.
    function automatic logic [127:0] beat_of(input int k);
        logic [127:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            b[127-16*j -: 16] = cur[8*k+j];
        end
        return b;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rel"}, rel, 0);
        chk({tag, "_calc"}, calculate, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic feed_frame(input int gap_pct);
        int i;
        int cyc;
        bit acc;
        i = 0;
        cyc = 0;
        while (i < 64 && cyc < 3000) begin
            in_data  = cur[i];
            in_valid = ($urandom_range(99) >= gap_pct);
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("samples_accepted", 128'(i), 128'd64);
    endtask

    task automatic issue_frame(input bit hold_valid, input int done_in_issue);
        for (int k = 0; k < 8; k++) begin
            if (hold_valid) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            chk($sformatf("rel_beat%0d", k), rel, 1);
            chk($sformatf("samples_beat%0d", k), samples, beat_of(k));
            chk($sformatf("calc_beat%0d", k), calculate, 1);
            chk($sformatf("busy_beat%0d", k), busy, 1);
            chk($sformatf("in_ready_beat%0d", k), in_ready, 0);
            done = (k == done_in_issue);
            step();
            done = 1'b0;
        end
    endtask

    task automatic wait_frame(input bit hold_valid, input int done_at);
        bit fin;
        fin = 1'b0;
        for (int w = 1; w <= 16 && !fin; w++) begin
            if (hold_valid) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            chk($sformatf("wait%0d_rel", w), rel, 0);
            chk($sformatf("wait%0d_calc", w), calculate, 1);
            chk($sformatf("wait%0d_busy", w), busy, 1);
            chk($sformatf("wait%0d_in_ready", w), in_ready, 0);
            chk($sformatf("wait%0d_err", w), timeout_err, exp_err);
            chk($sformatf("wait%0d_samples", w), samples, beat_of(7));
            done = (w == done_at);
            step();
            done = 1'b0;
            if (w == done_at) begin
                exp_fc = exp_fc + 16'd1;
                fin = 1'b1;
            end else if (w == 16) begin
                exp_err = 1'b1;
                fin = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("end_frame_count", frame_count, exp_fc);
        chk("end_timeout_err", timeout_err, exp_err);
        chk("end_in_ready", in_ready, 1);
        chk_idle_outputs("end");
    endtask

    task automatic run_frame(input int gap_pct, input bit hold_valid,
                             input int done_in_issue, input int done_at);
        feed_frame(gap_pct);
        issue_frame(hold_valid, done_in_issue);
        wait_frame(hold_valid, done_at);
        $display("frame done: frame_count=%0d timeout_err=%0d", frame_count, timeout_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_samples"}, samples, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_err"}, timeout_err, 0);
        chk_idle_outputs(tag);
    endtask

    initial begin
        sreset   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        done     = 1'b0;
        exp_fc   = '0;
        exp_err  = 1'b0;

        // reset then idle
        step();
        chk_all_zero("rst1");
        step();
        chk_all_zero("rst2");
        sreset = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        for (int c = 0; c < 20; c++) begin
            chk_idle_outputs("idle");
            step();
        end
        chk("idle_in_ready", in_ready, 1);
        $display("reset/idle done");

        // ramp frame, done 3 cycles after last rel
        for (int n = 0; n < 64; n++) cur[n] = 16'(n);
        run_frame(0, 1'b0, -1, 3);

        // sine frame with valid gaps; stray done during ISSUE must be ignored
        for (int n = 0; n < 64; n++) begin
            real v;
            v = $sin(2.0 * 3.14159265358979 * 1000.0 * n / 48000.0) * 256.0;
            cur[n] = 16'(int'(v));
        end
        run_frame(30, 1'b0, 3, 5);

        // back-pressure with changing data, done on the last allowed cycle
        for (int n = 0; n < 64; n++) cur[n] = 16'($urandom);
        run_frame(0, 1'b1, -1, 16);

        // timeout: done never arrives
        for (int n = 0; n < 64; n++) cur[n] = 16'($urandom);
        run_frame(0, 1'b1, -1, 0);

        // error stays sticky across a later good frame
        for (int n = 0; n < 64; n++) cur[n] = 16'($urandom);
        run_frame(50, 1'b0, -1, 1);

        // reset in the middle of ISSUE
        for (int n = 0; n < 64; n++) cur[n] = 16'(1000 + n);
        feed_frame(0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pre_rst_beat%0d", k), samples, beat_of(k));
            step();
        end
        chk("beat4_rel", rel, 1);
        sreset = 1'b1;
        step();
        chk_all_zero("midrst");
        sreset  = 1'b0;
        exp_fc  = '0;
        exp_err = 1'b0;
        step();
        chk("midrst_release_in_ready", in_ready, 1);
        $display("mid-issue reset done");

        for (int n = 0; n < 64; n++) cur[n] = 16'(2000 + n);
        run_frame(10, 1'b0, -1, 2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
